// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Sequencing stage in front of a combinational ALU. Holds a small register
//   file, accepts one instruction at a time over a valid/ready handshake,
//   presents registered operands to the ALU, captures its result and writes
//   it back. A load-immediate command seeds a register without the ALU.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (ready only while idle)
//   instr_cmd                bit2=1 load immediate, else ALU op_sel=cmd[1:0]
//   instr_rd/rs/rt           destination / operand A / operand B indices
//   instr_imm                immediate value for loads
//   alu_data_a/b, alu_op_sel registered drive to the ALU
//   alu_out, alu_zero        ALU result and zero indication
//   result, zero_flag        last written value / zero of last ALU op
//   done                     one-cycle completion pulse after writeback
//   dbg_addr, dbg_data       combinational register file read port
module alu_operand_sequencer #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_cmd,
  input  logic [2:0]       instr_rd,
  input  logic [2:0]       instr_rs,
  input  logic [2:0]       instr_rt,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [WIDTH-1:0] alu_data_a,
  output logic [WIDTH-1:0] alu_data_b,
  output logic [1:0]       alu_op_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             done,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       cmd_reg, rd_reg, rs_reg, rt_reg;
  logic [WIDTH-1:0] imm_reg;
  logic [WIDTH-1:0] alu_res_reg;
  logic [WIDTH-1:0] regs [NREGS];
  logic             accept;
  logic [WIDTH-1:0] wb_value;

  assign instr_ready = (state_reg == IDLE);
  assign accept      = instr_ready && instr_valid;
  // Loads bypass the ALU entirely, so the writeback source is chosen by cmd.
  assign wb_value    = cmd_reg[2] ? imm_reg : alu_res_reg;
  assign dbg_data    = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (instr_valid) state_next = instr_cmd[2] ? WB : READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Instruction fields are captured once at accept; instr_* is don't-care
  // for the rest of the operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_reg <= '0;
      rd_reg  <= '0;
      rs_reg  <= '0;
      rt_reg  <= '0;
      imm_reg <= '0;
    end else if (accept) begin
      cmd_reg <= instr_cmd;
      rd_reg  <= instr_rd;
      rs_reg  <= instr_rs;
      rt_reg  <= instr_rt;
      imm_reg <= instr_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_data_a  <= '0;
      alu_data_b  <= '0;
      alu_op_sel  <= '0;
      alu_res_reg <= '0;
      zero_flag   <= 1'b0;
      result      <= '0;
      done        <= 1'b0;
    end else begin
      // done follows the writeback cycle by exactly one clock.
      done <= (state_reg == WB);
      if (state_reg == READ) begin
        alu_data_a <= regs[rs_reg];
        alu_data_b <= regs[rt_reg];
        alu_op_sel <= cmd_reg[1:0];
      end
      // Operands have been stable for a full cycle by the time EXEC ends.
      if (state_reg == EXEC) begin
        alu_res_reg <= alu_out;
        zero_flag   <= alu_zero;
      end
      if (state_reg == WB) begin
        result <= wb_value;
      end
    end
  end

  // One flop row per register; operands were already latched in READ, so a
  // destination equal to a source needs no special handling.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
    always_ff @(posedge clk) begin
      if (rst) begin
        regs[gi] <= '0;
      end else if ((state_reg == WB) && (rd_reg == 3'(gi))) begin
        regs[gi] <= wb_value;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_cmd, instr_rd, instr_rs, instr_rt;
  logic [15:0] instr_imm;
  logic [15:0] alu_data_a, alu_data_b;
  logic [1:0]  alu_op_sel;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic [15:0] result;
  logic        zero_flag;
  logic        done;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  always #10 clk = ~clk;

  // Behavioural ALU stub.
  assign alu_out  = alu_data_a ^ alu_data_b;
  assign alu_zero = (alu_out == 16'h0000);

  alu_operand_sequencer #(.NREGS(8), .WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_cmd(instr_cmd), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_rt(instr_rt), .instr_imm(instr_imm),
    .alu_data_a(alu_data_a), .alu_data_b(alu_data_b), .alu_op_sel(alu_op_sel),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .result(result), .zero_flag(zero_flag), .done(done),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an instruction accepted at edge c completes by a latency
  // table (load: c+1; ALU op: operands c+1, flag c+2, writeback c+3), and the
  // next instruction may only be taken once the previous one has retired.
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  bit          started = 0;
  bit          inflight = 0;
  bit          was_ready;
  int          acc_cyc, k;
  int          acc_cnt = 0;
  int          done_exp_cnt = 0;
  logic [2:0]  m_cmd, m_rd, m_rs, m_rt;
  logic [15:0] m_imm;
  logic [15:0] m_regs [8];
  logic [15:0] m_a, m_b, m_res, m_cap;
  logic [1:0]  m_op;
  logic        m_zero, m_done, m_ready;

  task automatic m_writeback(input logic [15:0] v);
    m_regs[m_rd] = v;
    m_res        = v;
    m_done       = 1'b1;
    inflight     = 0;
    done_exp_cnt++;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      started  = 1;
      inflight = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_cap = 0;
      m_zero = 0; m_done = 0; m_ready = 1;
    end else begin
      was_ready = !inflight;
      m_done    = 1'b0;
      if (inflight) begin
        k = cyc - acc_cyc;
        if (m_cmd[2]) begin
          if (k == 1) m_writeback(m_imm);
        end else begin
          if (k == 1) begin
            m_a  = m_regs[m_rs];
            m_b  = m_regs[m_rt];
            m_op = m_cmd[1:0];
          end
          if (k == 2) begin
            m_cap  = m_a ^ m_b;
            m_zero = (m_cap == 16'h0000);
          end
          if (k == 3) m_writeback(m_cap);
        end
      end
      if (was_ready && instr_valid) begin
        m_cmd = instr_cmd; m_rd = instr_rd; m_rs = instr_rs;
        m_rt = instr_rt; m_imm = instr_imm;
        inflight = 1;
        acc_cyc  = cyc;
        acc_cnt++;
      end
      m_ready = !inflight;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare on the falling edge; dbg_addr sweeps every register.
  // ---------------------------------------------------------------------------
  int dut_done_cnt = 0;
  int acc_q [$];

  initial begin
    dbg_addr = 3'd0;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("instr_ready", {15'b0, instr_ready}, {15'b0, m_ready});
        chk("done",        {15'b0, done},        {15'b0, m_done});
        chk("zero_flag",   {15'b0, zero_flag},   {15'b0, m_zero});
        chk("result",      result,               m_res);
        chk("alu_data_a",  alu_data_a,           m_a);
        chk("alu_data_b",  alu_data_b,           m_b);
        chk("alu_op_sel",  {14'b0, alu_op_sel},  {14'b0, m_op});
        if (done === 1'b1) dut_done_cnt++;
        if (instr_ready === 1'b1 && instr_valid && !rst) acc_q.push_back(cyc);
        for (int a = 0; a < 8; a++) begin
          dbg_addr = 3'(a);
          #1;
          chk($sformatf("dbg_data[r%0d]", a), dbg_data, m_regs[a]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [2:0] cmd, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [15:0] imm, input bit hold);
    int start;
    bit ok;
    start       = acc_cnt;
    ok          = 0;
    instr_cmd   = cmd;
    instr_rd    = rd;
    instr_rs    = rs;
    instr_rt    = rt;
    instr_imm   = imm;
    instr_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != start) begin
        ok = 1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 20 cycles (cmd=%0d)", cmd);
    end
    $display("instr cmd=%0d rd=%0d rs=%0d rt=%0d imm=%h accepted at cycle %0d", cmd, rd, rs, rt, imm, cyc);
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0;
    instr_cmd = 0; instr_rd = 0; instr_rs = 0; instr_rt = 0; instr_imm = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1. Reset state.
    chk("t1_ready", {15'b0, instr_ready}, 16'd1);
    chk("t1_done",  {15'b0, done},        16'd0);
    chk("t1_zero",  {15'b0, zero_flag},   16'd0);
    repeat (2) step();

    // 2. Two loads of 20.
    issue(3'b100, 3'd1, 3'd0, 3'd0, 16'd20, 0);
    chk("t2_done_early", {15'b0, done}, 16'd0);
    step();
    chk("t2_done_r1", {15'b0, done}, 16'd1);
    chk("t2_result_r1", result, 16'd20);
    issue(3'b100, 3'd2, 3'd0, 3'd0, 16'd20, 0);
    step();
    chk("t2_done_r2", {15'b0, done}, 16'd1);
    chk("t2_zero", {15'b0, zero_flag}, 16'd0);
    chk("t2_model_r2", m_regs[2], 16'd20);
    step();

    // 3. r3 = r1 op r2 for each op_sel; stub gives 20^20 = 0.
    for (int i = 0; i < 4; i++) begin
      issue(3'(i), 3'd3, 3'd1, 3'd2, 16'h0, 0);
      step();
      chk("t3_a",  alu_data_a, 16'd20);
      chk("t3_b",  alu_data_b, 16'd20);
      chk("t3_op", {14'b0, alu_op_sel}, 16'(i));
      step();
      step();
      chk("t3_done",   {15'b0, done},      16'd1);
      chk("t3_result", result,             16'd0);
      chk("t3_zero",   {15'b0, zero_flag}, 16'd1);
      step();
      chk("t3_done_off", {15'b0, done}, 16'd0);
    end

    // 4. rd == rs.
    issue(3'b100, 3'd4, 3'd0, 3'd0, 16'h00FF, 0);
    step();
    issue(3'b001, 3'd4, 3'd4, 3'd2, 16'h0, 0);
    repeat (3) step();
    chk("t4_result", result, 16'h00EB);
    chk("t4_zero", {15'b0, zero_flag}, 16'd0);
    chk("t4_model_r4", m_regs[4], 16'h00EB);
    step();

    // 5. Three ops with valid held high.
    acc_q.delete();
    issue(3'b000, 3'd6, 3'd1, 3'd4, 16'h0, 1);
    issue(3'b010, 3'd7, 3'd6, 3'd2, 16'h0, 1);
    issue(3'b011, 3'd0, 3'd7, 3'd4, 16'h0, 0);
    repeat (5) step();
    chk("t5_accepts", 16'(acc_q.size()), 16'd3);
    if (acc_q.size() == 3) begin
      chk("t5_gap1", 16'(acc_q[1] - acc_q[0]), 16'd4);
      chk("t5_gap2", 16'(acc_q[2] - acc_q[1]), 16'd4);
    end

    // 6. Reset during EXEC aborts the write.
    issue(3'b000, 3'd5, 3'd4, 3'd2, 16'h0, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_done",   {15'b0, done},        16'd0);
    chk("t6_ready",  {15'b0, instr_ready}, 16'd1);
    chk("t6_result", result,               16'd0);
    chk("t6_a",      alu_data_a,           16'd0);
    chk("t6_b",      alu_data_b,           16'd0);
    chk("t6_op",     {14'b0, alu_op_sel},  16'd0);
    chk("t6_zero",   {15'b0, zero_flag},   16'd0);
    chk("t6_model_r5", m_regs[5], 16'd0);
    step();
    chk("t6_done_late", {15'b0, done}, 16'd0);
    issue(3'b100, 3'd5, 3'd0, 3'd0, 16'h1234, 0);
    step();
    chk("t6_load_r5", result, 16'h1234);
    step();

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  c;
      logic [15:0] imm;
      c   = 3'($urandom_range(0, 7));
      imm = 16'($urandom);
      if (($urandom % 4) == 0) imm = 16'h0000;
      issue(c, 3'($urandom), 3'($urandom), 3'($urandom), imm, ($urandom % 2) == 1);
      repeat ($urandom_range(0, 2)) step();
    end
    instr_valid = 1'b0;
    repeat (6) step();

    chk("done_count", 16'(dut_done_cnt), 16'(done_exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
